// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default widths and
// the FSM state type that tracks pipeline occupancy.
package mult_arb_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// NBitMultiplier: combinational N x N multiplier returning the low N bits of
// the product. Shared by all requesters of mult_share_arbiter.
module NBitMultiplier #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] product
);

  // Truncating multiply: only the low N bits of the product are kept.
  always_comb begin
    product = a * b;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbitration of NREQ operand streams onto a
// single shared multiplier. Pipeline is operand stage S1, the multiplier, then
// result stage S2 driving rsp_*. Defining MULT_SHARE_ARBITER_OUTREG_EN adds a
// third output register S3 (latency 3, same stall rules).
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int W    = DEF_W,
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  input  logic              rsp_ready
);

  // Operand stage S1
  logic           v1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic [IDW-1:0] id1;

  // Result stage S2
  logic           v2;
  logic [IDW-1:0] id2;
  logic [W-1:0]   d2;

  logic [W-1:0]   prod;
  logic           vlast;
  logic           advance;
  logic           accept;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] last_grant;
  logic           pipe_empty_next;

  arb_state_e state_q;
  arb_state_e state_d;

  NBitMultiplier #(.N(W)) u_mult (
    .a       (a1),
    .b       (b1),
    .product (prod)
  );

`ifdef MULT_SHARE_ARBITER_OUTREG_EN
  // Output stage S3
  logic           v3;
  logic [IDW-1:0] id3;
  logic [W-1:0]   d3;

  // Optional output register: one more cycle of latency, stalls with the pipe.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v3  <= 1'b0;
      id3 <= '0;
      d3  <= '0;
    end else if (advance) begin
      v3  <= v2;
      id3 <= id2;
      d3  <= d2;
    end
  end

  assign vlast           = v3;
  assign rsp_valid       = v3;
  assign rsp_id          = id3;
  assign rsp_data        = d3;
  assign pipe_empty_next = !accept && !v1 && !v2;
`else
  assign vlast           = v2;
  assign rsp_valid       = v2;
  assign rsp_id          = id2;
  assign rsp_data        = d2;
  assign pipe_empty_next = !accept && !v1;
`endif

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // One-hot ready for the winner, only while the pipe can move.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: follow grants, output stalls and pipeline drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (vlast && !rsp_ready) begin
          state_d = HOLD;
        end else if (pipe_empty_next) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          state_d = pipe_empty_next ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the pipe moves unless a held result is waiting on the consumer.
  always_comb begin
    advance = !vlast || rsp_ready;
    accept  = RSTn && advance && grant_found;
  end

  // Priority pointer moves only on a completed request handshake.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

  // S1 captures the winner's operands; a bubble enters when nobody wins.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      id1 <= '0;
    end else if (advance) begin
      v1 <= accept;
      if (accept) begin
        a1  <= req_a[grant_id*W +: W];
        b1  <= req_b[grant_id*W +: W];
        id1 <= grant_id;
      end
    end
  end

  // S2 registers the multiplier output together with its owner id.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v2  <= 1'b0;
      id2 <= '0;
      d2  <= '0;
    end else if (advance) begin
      v2  <= v1;
      id2 <= id1;
      d2  <= prod;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter. A queue-free array model of the
// pipeline slots plus a plain round-robin rule predicts every output.
module tb_mult_share_arbiter;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef MULT_SHARE_ARBITER_OUTREG_EN
  localparam int LAT  = 3;
`else
  localparam int LAT  = 2;
`endif

  logic              CLK = 1'b0;
  logic              RSTn = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ready = 1'b1;

  always #5 CLK = ~CLK;

  mult_share_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: LAT pipeline slots, slot LAT-1 is what the consumer sees.
  bit           m_v  [LAT];
  int           m_id [LAT];
  logic [W-1:0] m_d  [LAT];
  int           lastg;

  logic [NREQ-1:0] seenReady;
  logic            seenValid;
  logic [IDW-1:0]  seenId;
  logic [W-1:0]    seenData;
  int              respCount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < LAT; s++) begin
      m_v[s]  = 1'b0;
      m_id[s] = 0;
      m_d[s]  = '0;
    end
    lastg = NREQ - 1;
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(lastg + k) % NREQ]) return (lastg + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic checkOutput(input string tag, input bit adv, input int g);
    logic [NREQ-1:0] expReady;
    expReady = '0;
    if (adv && g >= 0) expReady[g] = 1'b1;
    chk({tag, "/req_ready"}, req_ready, expReady);
    chk({tag, "/rsp_valid"}, rsp_valid, m_v[LAT-1]);
    if (m_v[LAT-1]) begin
      chk({tag, "/rsp_id"}, rsp_id, m_id[LAT-1]);
      chk({tag, "/rsp_data"}, rsp_data, m_d[LAT-1]);
    end
  endtask

  task automatic runCycle(input string tag);
    bit           adv;
    int           g;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    @(negedge CLK);
    adv = !m_v[LAT-1] || rsp_ready;
    g   = adv ? rrPick(req_valid) : -1;
    checkOutput(tag, adv, g);
    seenReady = req_ready;
    seenValid = rsp_valid;
    seenId    = rsp_id;
    seenData  = rsp_data;
    if (rsp_valid === 1'b1 && rsp_ready) respCount++;
    @(posedge CLK);
    if (adv) begin
      for (int s = LAT - 1; s > 0; s--) begin
        m_v[s]  = m_v[s-1];
        m_id[s] = m_id[s-1];
        m_d[s]  = m_d[s-1];
      end
      m_v[0] = (g >= 0);
      if (g >= 0) begin
        pa      = req_a[g*W +: W];
        pb      = req_b[g*W +: W];
        m_d[0]  = pa * pb;
        m_id[0] = g;
        lastg   = g;
      end
    end
    #1;
  endtask

  task automatic doReset();
    RSTn = 1'b0;
    #1;
    chk("reset/rsp_valid", rsp_valid, 0);
    chk("reset/req_ready", req_ready, 0);
    chk("reset/rsp_id", rsp_id, 0);
    chk("reset/rsp_data", rsp_data, 0);
    modelReset();
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  logic [W-1:0] sa [8];
  logic [W-1:0] sb [8];
  int           k;

  initial begin
    modelReset();
    respCount = 0;
    #2;
    $display("[TB] reset");
    doReset();

    $display("[TB] single request from requester 0");
    applyStimulus(4'b0001, 1'b1);
    req_a[0 +: W] = 16'h0000;
    req_b[0 +: W] = 16'h1234;
    runCycle("single");
    chk("single/grant", seenReady, 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    for (int c = 1; c < LAT; c++) runCycle("single");
    chk("single/lat_valid", rsp_valid, 1);
    chk("single/lat_id", rsp_id, 0);
    chk("single/lat_data", rsp_data, 16'h0000);
    runCycle("single");
    runCycle("single");

    $display("[TB] all requesters, continuous");
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b1111, 1'b1);
      runCycle("allreq");
      chk("allreq/grant_seq", seenReady, 4'b0001 << (c % 4));
      if (c >= LAT) chk("allreq/id_seq", seenId, (c - LAT) % 4);
    end
    applyStimulus(4'b0000, 1'b1);
    for (int c = 0; c < LAT + 1; c++) runCycle("allreq_drain");

    $display("[TB] requester 2 stream with consumer stall");
    for (int i = 0; i < 8; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
    end
    k = 0;
    respCount = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus((k < 8) ? 4'b0100 : 4'b0000, !(c >= 4 && c <= 8));
      if (k < 8) begin
        req_a[2*W +: W] = sa[k];
        req_b[2*W +: W] = sb[k];
      end
      runCycle("stream");
      if (c >= 4 && c <= 8) chk("stream/stall_ready", seenReady, 0);
      if (seenReady[2] === 1'b1) k++;
    end
    chk("stream/result_count", respCount, 8);

    $display("[TB] reset with pipeline full");
    applyStimulus(4'b0010, 1'b1);
    for (int c = 0; c < LAT + 1; c++) runCycle("fill");
    doReset();
    applyStimulus(4'b1001, 1'b1);
    runCycle("post_reset");
    chk("post_reset/grant", seenReady, 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    for (int c = 0; c < LAT + 1; c++) runCycle("post_reset_drain");

    $display("[TB] round-robin 1 and 3");
    applyStimulus(4'b0010, 1'b1);
    runCycle("rr13");
    chk("rr13/first", seenReady, 4'b0010);
    applyStimulus(4'b1010, 1'b1);
    runCycle("rr13");
    chk("rr13/second", seenReady, 4'b1000);
    applyStimulus(4'b1010, 1'b1);
    runCycle("rr13");
    chk("rr13/third", seenReady, 4'b0010);
    applyStimulus(4'b0000, 1'b1);
    for (int c = 0; c < LAT + 1; c++) runCycle("rr13_drain");

    $display("[TB] random traffic");
    for (int c = 0; c < 80; c++) begin
      applyStimulus(NREQ'($urandom), ($urandom_range(0, 3) != 0));
      runCycle("random");
    end
    applyStimulus(4'b0000, 1'b1);
    for (int c = 0; c < LAT + 2; c++) runCycle("random_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
